// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard tracker.
// The rd field is sized for the widest supported register address; narrower addresses are zero-extended.
package fwd_pkg;

  localparam int FWD_RD_W        = 8;
  localparam int FWD_SEL_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                is_load;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source address against the in-flight entries; youngest match wins.
module fwd_match import fwd_pkg::*; #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int SEL_W = 2
) (
  input  fwd_entry_t       entries [DEPTH],
  input  logic [REG_W-1:0] rs_addr,
  output logic [SEL_W-1:0] sel
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel = SEL_W'(FWD_SEL_REGFILE);
    if (rs_addr != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entries[k].valid && entries[k].rd == FWD_RD_W'(rs_addr)) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_tracker.sv
// Forwarding and load-use hazard tracker: records destination registers of in-flight
// instructions and reports, per source port, which stage supplies the operand.
module fwd_tracker import fwd_pkg::*; #(
  parameter  int DEPTH        = 3,
  parameter  int NUM_RD       = 2,
  parameter  int REG_W        = 5,
  parameter  int FLUSH_STAGES = 1,
  localparam int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic                          issue_regwrite,
  input  logic                          issue_is_load,
  input  logic [REG_W-1:0]              issue_rd,
  input  logic [NUM_RD-1:0][REG_W-1:0]  rs_addr,
  input  logic [NUM_RD-1:0]             rs_used,
  output logic [NUM_RD-1:0][SEL_W-1:0]  fwd_sel,
  output logic                          load_use_hazard,
  output logic [SEL_W-1:0]              inflight_count
);

  if (REG_W > FWD_RD_W) begin : g_reg_w_check
    $error("fwd_tracker: REG_W exceeds fwd_pkg::FWD_RD_W");
  end

  fwd_entry_t       entries      [DEPTH];
  fwd_entry_t       entries_next [DEPTH];
  logic [SEL_W-1:0] count_next;

  // Flush beats stall; a flushed edge still advances the pipe but inserts only bubbles.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries_next[k] = entries[k];
    end
    if (flush) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries_next[k] = entries[k-1];
      end
      entries_next[0] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (k < FLUSH_STAGES) begin
          entries_next[k].valid = 1'b0;
        end
      end
    end else if (!stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries_next[k] = entries[k-1];
      end
      entries_next[0].valid   = issue_valid && issue_regwrite && (issue_rd != '0);
      entries_next[0].rd      = FWD_RD_W'(issue_rd);
      entries_next[0].is_load = issue_is_load;
    end
  end

  always_comb begin
    count_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entries_next[k].valid) begin
        count_next = count_next + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries        <= '{default: '0};
      inflight_count <= '0;
    end else begin
      entries        <= entries_next;
      inflight_count <= count_next;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_match
    fwd_match #(
      .DEPTH (DEPTH),
      .REG_W (REG_W),
      .SEL_W (SEL_W)
    ) u_match (
      .entries (entries),
      .rs_addr (rs_addr[i]),
      .sel     (fwd_sel[i])
    );
  end

  // Only the youngest entry can hold load data that is not yet forwardable.
  always_comb begin
    load_use_hazard = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rs_used[i] && rs_addr[i] != '0 && entries[0].valid && entries[0].is_load &&
          entries[0].rd == FWD_RD_W'(rs_addr[i])) begin
        load_use_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_tracker.sv
// Directed-vector bench for fwd_tracker; a second instance uses FLUSH_STAGES=2.
module tb_fwd_tracker;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall, flush;
  logic            issue_valid, issue_regwrite, issue_is_load;
  logic [4:0]      issue_rd;
  logic [1:0][4:0] rs_addr;
  logic [1:0]      rs_used;
  logic [1:0][1:0] fwd_sel, fwd_sel_f2;
  logic            load_use_hazard, load_use_hazard_f2;
  logic [1:0]      inflight_count, inflight_count_f2;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  fwd_tracker #(.DEPTH(3), .NUM_RD(2), .REG_W(5), .FLUSH_STAGES(1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .rs_addr(rs_addr), .rs_used(rs_used),
    .fwd_sel(fwd_sel), .load_use_hazard(load_use_hazard),
    .inflight_count(inflight_count)
  );

  fwd_tracker #(.DEPTH(3), .NUM_RD(2), .REG_W(5), .FLUSH_STAGES(2)) dut_f2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .rs_addr(rs_addr), .rs_used(rs_used),
    .fwd_sel(fwd_sel_f2), .load_use_hazard(load_use_hazard_f2),
    .inflight_count(inflight_count_f2)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one edge's worth of control/issue inputs, then settle just after the edge.
  task automatic applyStimulus(input logic v, input logic rw, input logic ld,
                               input logic [4:0] rd, input logic st, input logic fl);
    issue_valid    = v;
    issue_regwrite = rw;
    issue_is_load  = ld;
    issue_rd       = rd;
    stall          = st;
    flush          = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic issueAlu(input logic [4:0] rd);
    applyStimulus(1'b1, 1'b1, 1'b0, rd, 1'b0, 1'b0);
  endtask

  task automatic setRead(input logic [4:0] a0, input logic [4:0] a1,
                         input logic u0, input logic u1);
    rs_addr[0] = a0;
    rs_addr[1] = a1;
    rs_used[0] = u0;
    rs_used[1] = u1;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
    rs_addr = '0; rs_used = '0;
    repeat (2) @(posedge clk);
    #1;
    setRead(5'd5, 5'd0, 1'b1, 1'b0);
    checkOutput("reset_sel0", fwd_sel[0], 0);
    checkOutput("reset_hazard", load_use_hazard, 0);
    checkOutput("reset_count", inflight_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back dependency and aging through the pipe
    issueAlu(5'd5);
    setRead(5'd5, 5'd0, 1'b1, 1'b0);
    checkOutput("b2b_sel_e0", fwd_sel[0], 1);
    checkOutput("b2b_count1", inflight_count, 1);
    issueAlu(5'd6);
    issueAlu(5'd10);
    checkOutput("b2b_sel_e2", fwd_sel[0], 3);
    checkOutput("b2b_count3", inflight_count, 3);
    issueAlu(5'd11);
    checkOutput("b2b_sel_retired", fwd_sel[0], 0);
    checkOutput("b2b_count_sat", inflight_count, 3);

    // Drain with bubbles
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("drain_count", inflight_count, 0);

    // Youngest wins, x0 never recorded
    issueAlu(5'd7);
    issueAlu(5'd7);
    setRead(5'd7, 5'd0, 1'b1, 1'b0);
    checkOutput("young_sel", fwd_sel[0], 1);
    checkOutput("young_count", inflight_count, 2);
    issueAlu(5'd0);
    setRead(5'd0, 5'd7, 1'b1, 1'b1);
    checkOutput("x0_sel", fwd_sel[0], 0);
    checkOutput("x0_count", inflight_count, 2);
    checkOutput("x0_older_sel", fwd_sel[1], 2);

    // Load-use hazard, stall, bubble release
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    setRead(5'd0, 5'd9, 1'b0, 1'b1);
    checkOutput("lu_hazard", load_use_hazard, 1);
    checkOutput("lu_sel", fwd_sel[1], 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
    checkOutput("lu_stall_hazard", load_use_hazard, 1);
    checkOutput("lu_stall_sel", fwd_sel[1], 1);
    checkOutput("lu_stall_count", inflight_count, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("lu_bubble_hazard", load_use_hazard, 0);
    checkOutput("lu_bubble_sel", fwd_sel[1], 2);
    checkOutput("lu_bubble_count", inflight_count, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    setRead(5'd0, 5'd9, 1'b0, 1'b0);
    checkOutput("lu_unused_hazard", load_use_hazard, 0);
    checkOutput("lu_unused_sel", fwd_sel[1], 1);
    setRead(5'd9, 5'd0, 1'b1, 1'b0);
    checkOutput("lu_port0_hazard", load_use_hazard, 1);

    // Stall hold with a valid issue presented
    issueAlu(5'd20);
    issueAlu(5'd21);
    issueAlu(5'd22);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
      setRead(5'd12, 5'd22, 1'b1, 1'b1);
      checkOutput("stall_no12", fwd_sel[0], 0);
      checkOutput("stall_count", inflight_count, 3);
    end
    setRead(5'd20, 5'd22, 1'b1, 1'b1);
    checkOutput("stall_old_sel", fwd_sel[0], 3);
    checkOutput("stall_young_sel", fwd_sel[1], 1);

    // Flush overrides stall
    issueAlu(5'd5);
    issueAlu(5'd4);
    issueAlu(5'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    setRead(5'd8, 5'd3, 1'b1, 1'b1);
    checkOutput("flush1_no8", fwd_sel[0], 0);
    checkOutput("flush1_sel3", fwd_sel[1], 2);
    checkOutput("flush1_count", inflight_count, 2);
    checkOutput("flush2_sel3", fwd_sel_f2[1], 0);
    checkOutput("flush2_count", inflight_count_f2, 1);
    setRead(5'd4, 5'd0, 1'b1, 1'b0);
    checkOutput("flush1_sel4", fwd_sel[0], 3);
    checkOutput("flush2_sel4", fwd_sel_f2[0], 3);

    // Asynchronous reset between edges
    issueAlu(5'd1);
    issueAlu(5'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    setRead(5'd3, 5'd1, 1'b1, 1'b1);
    checkOutput("pre_rst_hazard", load_use_hazard, 1);
    checkOutput("pre_rst_count", inflight_count, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sel0", fwd_sel[0], 0);
    checkOutput("arst_sel1", fwd_sel[1], 0);
    checkOutput("arst_hazard", load_use_hazard, 0);
    checkOutput("arst_count", inflight_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issueAlu(5'd14);
    setRead(5'd14, 5'd0, 1'b1, 1'b0);
    checkOutput("post_rst_sel", fwd_sel[0], 1);
    checkOutput("post_rst_count", inflight_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/fwd_tracker.md
Name: fwd_tracker

Overview:
- Parametrised forwarding and hazard unit for the pipelined RISC-V core.
- Tracks the destination registers of the last DEPTH register-writing instructions in flight, youngest first.
- For each of NUM_RD source-read ports it returns which pipeline stage supplies the operand; 0 means the register file.
- Adds stall hold, flush and load-use hazard detection, so the decode stage can bypass, stall or kill without further logic.

Parameters:
- DEPTH, 3, number of in-flight stages tracked (EX/MEM/WB = 3); legal 1..7.
- NUM_RD, 2, number of source-read ports.
- REG_W, 5, register address width.
- FLUSH_STAGES, 1, number of youngest entries invalidated on flush; legal 0..DEPTH.
- SEL_W, $clog2(DEPTH+1), derived width of each select; not overridable.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all tracker entries this cycle.
- flush  in  1  invalidate the FLUSH_STAGES youngest entries and discard the issuing instruction.
- issue_valid  in  1  instruction leaving decode this cycle.
- issue_regwrite  in  1  issuing instruction writes rd.
- issue_is_load  in  1  issuing instruction is a load.
- issue_rd  in  REG_W  destination register of the issuing instruction.
- rs_addr  in  NUM_RD x REG_W  source register address per port.
- rs_used  in  NUM_RD  port is actually read by the decoding instruction.
- fwd_sel  out  NUM_RD x SEL_W  per port: 0 = register file, k = forward from entry k-1.
- load_use_hazard  out  1  decode must stall one cycle.
- inflight_count  out  SEL_W  number of valid entries.

Behaviour:
- State: entry[0..DEPTH-1], each holding {valid, rd, is_load}. entry[0] is youngest (one stage past decode); entry[DEPTH-1] is oldest (writeback).
- Reset, asynchronous on rst_n low: all entries valid=0, rd=0, is_load=0.
  - Outputs during and after reset: fwd_sel all 0, load_use_hazard 0, inflight_count 0.
  - Reset mid-operation drops all tracked writes immediately.
- Per rising edge, in priority order:
  - flush=1:
    - Shift one position (entry[k] <= entry[k-1]; entry[DEPTH-1] retires).
    - entry[0] <= invalid.
    - Entries at indices < FLUSH_STAGES after the shift are forced invalid.
    - Flush overrides stall.
  - else stall=1: all entries hold; the issue inputs are ignored.
  - else: shift one position. entry[0] <= {issue_valid & issue_regwrite & (issue_rd!=0), issue_rd, issue_is_load}.
- Bubbles: an invalid entry still shifts (it represents the bubble); it never matches.
- x0: never recorded as valid. A port with rs_addr==0 always returns fwd_sel=0 and never raises a hazard.
- fwd_sel[i], combinational from the current entries:
  - Value is the smallest k+1 such that entry[k].valid and entry[k].rd==rs_addr[i]; else 0.
  - Youngest match wins when several entries share the same rd.
  - Independent of rs_used, so unused ports may show nonzero selects.
- load_use_hazard, combinational: 1 iff some port i has rs_used[i], rs_addr[i]!=0, entry[0].valid, entry[0].is_load and entry[0].rd==rs_addr[i].
  - Only entry[0] is considered; older load data is forwardable.
  - The expected system response is stall=1 next edge, which the tracker obeys like any other stall.
- inflight_count: population count of valid entries. Registered, updated on the same edge as the entries. Range 0..DEPTH.
- Latency: an instruction issued at edge n is visible in fwd_sel after edge n (as entry[0]) and drops out after DEPTH non-stalled edges.

Decomposition:
- Shared package fwd_pkg:
  - typedef fwd_entry_t {logic valid; logic [REG_W-1:0] rd; logic is_load;}.
  - Select-encoding constant FWD_SEL_REGFILE=0.
- One natural sub-module: fwd_match, a combinational priority match of one rs_addr against the entry array returning SEL_W. It is instantiated NUM_RD times in a generate loop.
- The hazard OR-reduction and the population count stay in the top.

Test Plan:
- Back-to-back dependency, DEPTH=3: issue rd=5 (ALU), then read rs_addr[0]=5 → fwd_sel[0]=1. After two more non-stalled issues of other rd → fwd_sel[0]=3. One more → 0, inflight_count stays ≤3.
- Youngest wins: issue rd=7, then rd=7 again; read rs=7 → fwd_sel=1, not 2. Read rs=0 with x0 issues interleaved → fwd_sel=0, x0 issue leaves inflight_count unchanged.
- Load-use: issue load rd=9, next cycle rs_addr[1]=9, rs_used[1]=1 → load_use_hazard=1. Assert stall one edge; entries hold. Deassert stall → entries shift with a bubble at entry[0] (issue_valid=0), hazard=0, fwd_sel[1]=2. Same case with rs_used[1]=0 → hazard=0.
- Stall hold: three valid entries, stall held 4 edges with issue_valid=1, rd=12 → entries unchanged, no rd=12 match, inflight_count constant.
- Flush priority, FLUSH_STAGES=1: entries rd={3,4,5}, assert flush and stall with issue rd=8 → after edge entries {inv,3,4} (entry[0] invalid, no match for 8), inflight_count=2. With FLUSH_STAGES=2 → {inv,inv,4}, count=1.
- Async reset: deassert rst_n between edges with full tracker → fwd_sel, hazard and count go 0 without a clock edge. Release → first issue lands in entry[0].
